uart_rx: RTL and testbench

- UART receiver with 16x oversampling. Turns the serial line into parallel data words.
- Driven by the periodic tick from the baud-rate counter: the counter's done output connects to this block's s_tick, giving 16 ticks per bit period.
- Frame format: 1 start bit (low), DBIT data bits sent LSB first, stop bit(s) (high).
- Delivers each received word with a one-cycle done strobe and a framing-error flag. Sits between the pad-side rx line and the host-side consumer.

---
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Host-side view of the UART receiver: received word, its strobe and status.
// rx_done is a one-cycle valid with no ready (the consumer cannot stall);
// dout and frame_err are valid in that cycle and hold until the next rx_done.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] dout;
  logic            rx_done;
  logic            frame_err;
  logic            busy;

  modport master (output dout, rx_done, frame_err, busy);
  modport slave  (input  dout, rx_done, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start-bit qualification at mid-bit,
// LSB-first data capture, stop-bit framing check and a one-cycle done strobe.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       rx,
  uart_rx_if.master  bus,
  output logic [1:0] dbg_state
);

  localparam int SW = $clog2(SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] shreg, shreg_n;
  logic [DBIT-1:0] dout_q, dout_n;
  logic            err_q, err_n;
  logic            done_q, done_n;
  logic            rx_meta, rx_s;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      shreg  <= '0;
      dout_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      s      <= s_n;
      n      <= n_n;
      shreg  <= shreg_n;
      dout_q <= dout_n;
      err_q  <= err_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    shreg_n = shreg;
    dout_n  = dout_q;
    err_n   = err_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        // Start detection runs every clk so the tick phase cannot hide an edge.
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == SW'(7)) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            shreg_n = {rx_s, shreg[DBIT-1:1]};
            s_n     = '0;
            if (n == NW'(DBIT - 1)) state_n = STOP;
            else                    n_n     = n + 1'b1;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            dout_n  = shreg;
            err_n   = ~rx_s;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.dout      = dout_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state != IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one SB_TICK=16 receiver and one SB_TICK=32 receiver,
// frames driven bit-by-bit against a word/latency model derived from the frame format.
module tb_uart_rx;

  localparam int TICK_CLK = 4;
  localparam int LAT16    = TICK_CLK * (8 + 16 * 8 + 16);
  localparam int LAT32    = TICK_CLK * (8 + 16 * 8 + 32);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_tick = 1'b0;
  logic tick_en = 1'b1;
  logic rx_line = 1'b1;
  logic use_b = 1'b0;
  logic rx_a, rx_b;
  logic [1:0] dbg_a, dbg_b;

  assign rx_a = rx_line;
  assign rx_b = use_b ? rx_line : 1'b1;

  uart_rx_if #(.DBIT(8)) bus_a ();
  uart_rx_if #(.DBIT(8)) bus_b ();

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut_a (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_a), .bus(bus_a), .dbg_state(dbg_a)
  );
  uart_rx #(.DBIT(8), .SB_TICK(32)) dut_b (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_b), .bus(bus_b), .dbg_state(dbg_b)
  );

  // ---------------- clock / tick ----------------
  always #5 clk = ~clk;

  int tick_cnt = 0;
  always @(negedge clk) begin
    if (tick_en) begin
      s_tick   = (tick_cnt == TICK_CLK - 1);
      tick_cnt = (tick_cnt + 1) % TICK_CLK;
    end else begin
      s_tick = 1'b0;
    end
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitors ----------------
  logic [8:0] got_a[$];
  logic [8:0] got_b[$];
  longint     done_a[$];
  longint     done_b[$];
  int         wide_a = 0;
  logic       prev_a = 1'b0;

  always @(negedge clk) begin
    if (bus_a.rx_done) begin
      got_a.push_back({bus_a.frame_err, bus_a.dout});
      done_a.push_back(cyc);
      if (prev_a) wide_a++;
    end
    prev_a = bus_a.rx_done;
    if (bus_b.rx_done) begin
      got_b.push_back({bus_b.frame_err, bus_b.dout});
      done_b.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- model / counters ----------------
  int         total = 0;
  int         bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last_word = '0;
  longint     frame_start = 0;

  // ---------------- drivers ----------------
  task automatic wait_ticks(input int k);
    repeat (k) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  // Stop bit lasts stop_ticks; its first stop_low ticks are driven low.
  task automatic send_frame(input logic [7:0] d, input int stop_ticks, input int stop_low);
    frame_start = cyc;
    rx_line = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      wait_ticks(16);
    end
    if (stop_low > 0) begin
      rx_line = 1'b0;
      wait_ticks(stop_low);
    end
    rx_line = 1'b1;
    wait_ticks(stop_ticks - stop_low);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total++; if (bus_a.dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", bus_a.dout); end
    total++; if (bus_a.rx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus_a.rx_done); end
    total++; if (bus_a.frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus_a.frame_err); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    total++; if (dbg_a !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_a); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_basic();
    logic [8:0] w;
    longint st;
    got_a.delete(); done_a.delete();
    send_frame(8'hA5, 16, 0);
    st = frame_start;
    last_word = {1'b0, 8'hA5};
    w = (got_a.size() > 0) ? got_a[0] : 9'h1ff;
    total++; if (got_a.size() != 1) begin bad++; $display("FAIL basic_count: got %0d want 1", got_a.size()); end
    total++; if (w !== {1'b0, 8'hA5}) begin bad++; $display("FAIL basic_word: got %h want %h", w, {1'b0, 8'hA5}); end
    total++; if (done_a.size() == 0 || done_a[0] - st != LAT16) begin
      bad++; $display("FAIL basic_latency: got %0d want %0d", (done_a.size() > 0) ? done_a[0] - st : -1, LAT16);
    end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", bus_a.busy); end
    total++; if (wide_a != 0) begin bad++; $display("FAIL basic_pulse_width: got %0d wide pulses want 0", wide_a); end
  endtask

  task automatic test_framing_error();
    logic [8:0] w;
    got_a.delete();
    send_frame(8'h3C, 16, 10);
    total++; if (bus_a.frame_err !== 1'b1) begin bad++; $display("FAIL ferr_flag: got %b want 1", bus_a.frame_err); end
    send_frame(8'h81, 16, 0);
    last_word = {1'b0, 8'h81};
    total++; if (got_a.size() != 2) begin bad++; $display("FAIL ferr_count: got %0d want 2", got_a.size()); end
    w = (got_a.size() > 0) ? got_a[0] : 9'h1ff;
    total++; if (w !== {1'b1, 8'h3C}) begin bad++; $display("FAIL ferr_word: got %h want %h", w, {1'b1, 8'h3C}); end
    w = (got_a.size() > 1) ? got_a[1] : 9'h1ff;
    total++; if (w !== {1'b0, 8'h81}) begin bad++; $display("FAIL ferr_clear: got %h want %h", w, {1'b0, 8'h81}); end
  endtask

  task automatic test_glitch();
    got_a.delete();
    rx_line = 1'b0;
    wait_ticks(3);
    total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_during: got %b want 1", bus_a.busy); end
    rx_line = 1'b1;
    wait_ticks(20);
    total++; if (dbg_a !== 2'd0 || bus_a.busy !== 1'b0) begin
      bad++; $display("FAIL glitch_idle: got state %0d busy %b want 0 0", dbg_a, bus_a.busy);
    end
    total++; if (got_a.size() != 0) begin bad++; $display("FAIL glitch_no_done: got %0d pulses want 0", got_a.size()); end
    total++; if ({bus_a.frame_err, bus_a.dout} !== last_word) begin
      bad++; $display("FAIL glitch_dout_held: got %h want %h", {bus_a.frame_err, bus_a.dout}, last_word);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] w;
    got_a.delete();
    rx_line = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx_line = 1'b1;
      wait_ticks(16);
    end
    rx_line = 1'b1;
    wait_ticks(8);
    rst = 1'b1;
    #2;
    total++; if ({bus_a.rx_done, bus_a.frame_err, bus_a.busy, bus_a.dout} !== 11'h0) begin
      bad++; $display("FAIL rstmid_outputs: got done %b err %b busy %b dout %h want all 0",
                      bus_a.rx_done, bus_a.frame_err, bus_a.busy, bus_a.dout);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(40);
    total++; if (got_a.size() != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", got_a.size()); end
    send_frame(8'h12, 16, 0);
    last_word = {1'b0, 8'h12};
    w = (got_a.size() > 0) ? got_a[0] : 9'h1ff;
    total++; if (got_a.size() != 1 || w !== {1'b0, 8'h12}) begin
      bad++; $display("FAIL rstmid_next: got %0d pulses word %h want 1 pulse %h", got_a.size(), w, {1'b0, 8'h12});
    end
  endtask

  task automatic test_back_to_back();
    longint st1 = 0;
    int     snap_n;
    got_a.delete(); done_a.delete();
    fork
      begin
        send_frame(8'h00, 16, 0);
        send_frame(8'hFF, 16, 0);
      end
      begin
        #1 st1 = frame_start;
        wait_ticks(40);
        tick_en = 1'b0;
        snap_n = got_a.size();
        repeat (50) @(posedge clk);
        total++; if (bus_a.busy !== 1'b1 || got_a.size() != snap_n) begin
          bad++; $display("FAIL stall_frozen: got busy %b pulses %0d want 1 %0d", bus_a.busy, got_a.size(), snap_n);
        end
        #1 tick_en = 1'b1;
      end
    join
    last_word = {1'b0, 8'hFF};
    total++; if (got_a.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", got_a.size()); end
    total++; if (got_a.size() != 2 || got_a[0] !== {1'b0, 8'h00} || got_a[1] !== {1'b0, 8'hFF}) begin
      bad++; $display("FAIL b2b_words: got %p want 000 0ff", got_a);
    end
    total++; if (done_a.size() == 0 || done_a[0] - st1 != LAT16 + 50) begin
      bad++; $display("FAIL stall_latency: got %0d want %0d", (done_a.size() > 0) ? done_a[0] - st1 : -1, LAT16 + 50);
    end
    total++; if (done_a.size() < 2 || done_a[1] - done_a[0] != TICK_CLK * 160) begin
      bad++; $display("FAIL b2b_spacing: got %0d want %0d", (done_a.size() > 1) ? done_a[1] - done_a[0] : -1, TICK_CLK * 160);
    end
  endtask

  task automatic test_two_stop();
    logic [8:0] wb;
    longint st;
    got_a.delete(); done_a.delete(); got_b.delete(); done_b.delete();
    use_b = 1'b1;
    send_frame(8'h5A, 32, 0);
    st = frame_start;
    use_b = 1'b0;
    last_word = {1'b0, 8'h5A};
    wb = (got_b.size() > 0) ? got_b[0] : 9'h1ff;
    total++; if (got_b.size() != 1 || wb !== {1'b0, 8'h5A}) begin
      bad++; $display("FAIL two_stop_word: got %0d pulses word %h want 1 pulse %h", got_b.size(), wb, {1'b0, 8'h5A});
    end
    total++; if (done_b.size() == 0 || done_b[0] - st != LAT32) begin
      bad++; $display("FAIL two_stop_latency: got %0d want %0d", (done_b.size() > 0) ? done_b[0] - st : -1, LAT32);
    end
    total++; if (done_a.size() == 0 || done_b.size() == 0 || done_b[0] - done_a[0] != TICK_CLK * 16) begin
      bad++; $display("FAIL two_stop_delta: got %0d want %0d",
                      (done_a.size() > 0 && done_b.size() > 0) ? done_b[0] - done_a[0] : -1, TICK_CLK * 16);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       e;
    logic [8:0] g, x;
    int         nexp;
    got_a.delete(); exp_q.delete();
    wide_a = 0;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      e = ($urandom_range(0, 3) == 0);
      exp_q.push_back({e, d});
      send_frame(d, 16, e ? 10 : 0);
      wait_ticks($urandom_range(0, 20));
    end
    nexp = exp_q.size();
    total++; if (got_a.size() != nexp) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_a.size(), nexp); end
    for (int i = 0; i < nexp; i++) begin
      x = exp_q.pop_front();
      g = (got_a.size() > 0) ? got_a.pop_front() : 9'h1ff;
      total++; if (g !== x) begin bad++; $display("FAIL rand_word[%0d]: got %h want %h", i, g, x); end
    end
    total++; if (wide_a != 0) begin bad++; $display("FAIL rand_pulse_width: got %0d wide pulses want 0", wide_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_framing_error();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_two_stop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
